boxcar_averager: RTL and testbench

- Triggered boxcar integrator/averager that sits directly downstream of the custom-instrument input ports.
- Takes one signed 16-bit ADC channel (inputa) and the external trigger (exttrig). After each trigger it waits a programmable delay, then integrates a programmable gate window.
- Averages 2^N shots and emits a saturated 16-bit result. The result drives an instrument output (outputa); counts are exported to status registers.
- Delay, gate, N and output shift come from control registers.

---
 rtl/boxcar_averager.sv | 173 +++++++++++++++++
 tb/tb_boxcar_averager.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/boxcar_averager.sv
// -----------------------------------------------------------------------------
// boxcar_averager
//   Triggered boxcar integrator/averager for one signed ADC channel.
//   On each rising trigger edge accepted in IDLE it waits `delay` samples,
//   sums `gate_len` consecutive samples into shot_sum, and adds that shot
//   into avg_acc. After 2^avg_log2 shots it emits a saturated, arithmetically
//   shifted result on dout with a one-cycle dout_valid pulse.
//
// Ports
//   clk, reset     sample clock, asynchronous active-high reset
//   enable         run enable; low aborts the current shot/average
//   din            signed sample
//   trig_in        trigger level; the rising edge is the event
//   delay          samples from trigger to gate start (latched per shot)
//   gate_len       gate width in samples, 0 behaves as 1 (latched per shot)
//   avg_log2       shots per average = 2^avg_log2, clamped to 16
//   out_shift      arithmetic right shift applied before saturation
//   dout           saturated result, held between updates
//   dout_valid     one-cycle pulse on dout update
//   busy           state != IDLE
//   shot_cnt       accepted triggers (wrapping)
//   missed_cnt     triggers ignored while busy
//
// Build option
//   BOXCAR_MISSED_CNT_EN  when defined, missed_cnt counts (saturating) events
//                         that arrive with enable=1 outside IDLE; otherwise
//                         missed_cnt is tied to 0.
// -----------------------------------------------------------------------------
module boxcar_averager #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    parameter int ACC_W  = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] din,
    input  logic              trig_in,
    input  logic [CNT_W-1:0]  delay,
    input  logic [CNT_W-1:0]  gate_len,
    input  logic [4:0]        avg_log2,
    input  logic [5:0]        out_shift,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic [31:0]       shot_cnt,
    output logic [15:0]       missed_cnt
);

    localparam int SUM_W = DATA_W + CNT_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DELAY, INTEG, EMIT} state_t;

    state_t                  state, state_nx;
    logic                    trig_d, trig_evt, accept, last;
    logic [CNT_W-1:0]        cnt, gate_l, gate_eff;
    logic [4:0]              avg_l;
    logic [5:0]              shift_l;
    logic signed [SUM_W-1:0] shot_sum, shot_total;
    logic signed [ACC_W-1:0] avg_acc, acc_shift;
    logic [16:0]             shots_done, shots_inc, shots_tgt;
    logic [DATA_W-1:0]       sat_val;

    assign trig_evt   = trig_in & ~trig_d;
    assign accept     = enable && (state == IDLE) && trig_evt;
    assign last       = (state == INTEG) && (cnt == '0);
    assign gate_eff   = (gate_len == '0) ? CNT_W'(1) : gate_len;
    assign shot_total = shot_sum + {{CNT_W{din[DATA_W-1]}}, din};
    assign shots_inc  = shots_done + 17'd1;
    assign shots_tgt  = 17'd1 << avg_l;
    assign acc_shift  = avg_acc >>> shift_l;  // shifts >= ACC_W collapse to 0 / -1
    assign busy       = (state != IDLE);

    always_comb begin
        if (acc_shift > SAT_MAX)
            sat_val = {1'b0, {(DATA_W-1){1'b1}}};
        else if (acc_shift < SAT_MIN)
            sat_val = {1'b1, {(DATA_W-1){1'b0}}};
        else
            sat_val = acc_shift[DATA_W-1:0];
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nx = (delay != '0) ? DELAY : INTEG;
                DELAY:   if (cnt == '0) state_nx = INTEG;
                INTEG:   if (last) state_nx = (shots_inc == shots_tgt) ? EMIT : IDLE;
                EMIT:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // ---------------- datapath ----------------
    // cnt is shared: it counts down the delay, then is reloaded for the gate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_d     <= 1'b0;
            cnt        <= '0;
            gate_l     <= '0;
            avg_l      <= '0;
            shift_l    <= '0;
            shot_sum   <= '0;
            avg_acc    <= '0;
            shots_done <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            shot_cnt   <= '0;
        end else begin
            trig_d     <= trig_in;
            dout_valid <= 1'b0;
            if (!enable) begin
                shot_sum   <= '0;
                avg_acc    <= '0;
                shots_done <= '0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        gate_l   <= gate_eff;
                        avg_l    <= (avg_log2 > 5'd16) ? 5'd16 : avg_log2;
                        shift_l  <= out_shift;
                        cnt      <= (delay != '0) ? delay - CNT_W'(1) : gate_eff - CNT_W'(1);
                        shot_sum <= '0;
                        shot_cnt <= shot_cnt + 32'd1;
                    end
                    DELAY: cnt <= (cnt == '0) ? gate_l - CNT_W'(1) : cnt - CNT_W'(1);
                    INTEG: begin
                        if (last) begin
                            avg_acc    <= avg_acc + {{(ACC_W-SUM_W){shot_total[SUM_W-1]}}, shot_total};
                            shots_done <= shots_inc;
                            shot_sum   <= '0;
                        end else begin
                            shot_sum <= shot_total;
                            cnt      <= cnt - CNT_W'(1);
                        end
                    end
                    EMIT: begin
                        dout       <= sat_val;
                        dout_valid <= 1'b1;
                        avg_acc    <= '0;
                        shots_done <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef BOXCAR_MISSED_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            missed_cnt <= '0;
        else if (enable && trig_evt && (state != IDLE) && (missed_cnt != 16'hFFFF))
            missed_cnt <= missed_cnt + 16'd1;
    end
`else
    assign missed_cnt = '0;
`endif

endmodule

// File: tb/tb_boxcar_averager.sv
// Scoreboard bench for boxcar_averager: each shot's expected contribution is
// computed from the din values actually driven inside its gate window; when
// an average completes, the expected result and its cycle are queued and a
// monitor compares them against every dout_valid pulse.
module tb_boxcar_averager;

    logic               clk = 1'b0;
    logic               reset, enable, trig_in;
    logic signed [15:0] din;
    logic [15:0]        delay, gate_len;
    logic [4:0]         avg_log2;
    logic [5:0]         out_shift;
    logic signed [15:0] dout;
    logic               dout_valid, busy;
    logic [31:0]        shot_cnt;
    logic [15:0]        missed_cnt;

    boxcar_averager #(.DATA_W(16), .CNT_W(16), .ACC_W(48)) dut (
        .clk(clk), .reset(reset), .enable(enable), .din(din), .trig_in(trig_in),
        .delay(delay), .gate_len(gate_len), .avg_log2(avg_log2), .out_shift(out_shift),
        .dout(dout), .dout_valid(dout_valid), .busy(busy),
        .shot_cnt(shot_cnt), .missed_cnt(missed_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { longint val; int at; } exp_t;
    exp_t   sb_q[$];
    exp_t   mon_e;
    int     total = 0, bad = 0;
    longint m_acc = 0;
    int     m_shots = 0, exp_shots = 0, exp_missed = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        din = 16'($urandom());
    endtask

    // One shot: trigger, then drive the delay + gate window. Config inputs are
    // scrambled after the trigger to show they only matter at the event.
    task automatic do_shot(input int d, input int g, input int n, input int sh,
                           input bit use_val, input int val, input int extra_at, input bit hold);
        int     geff = (g == 0) ? 1 : g;
        int     t;
        longint sum = 0;
        tick();
        delay = 16'(d); gate_len = 16'(g); avg_log2 = 5'(n); out_shift = 6'(sh);
        trig_in = 1'b1;
        t = cyc;
        exp_shots++;
        for (int k = 1; k <= d + geff; k++) begin
            tick();
            if (!hold) trig_in = (extra_at != 0) && (k == extra_at);
            delay = 16'($urandom()); gate_len = 16'($urandom());
            avg_log2 = 5'($urandom()); out_shift = 6'($urandom());
            if (use_val) din = 16'(val);
            if (k > d) sum += din;
            if (k == 1) check("busy_in_shot", busy, 1);
`ifdef BOXCAR_MISSED_CNT_EN
            if (!hold && extra_at != 0 && k == extra_at) exp_missed++;
`endif
        end
        m_acc += sum;
        m_shots++;
        if (m_shots == (1 << n)) begin
            sb_q.push_back('{sat16(m_acc >>> sh), t + d + geff + 2});
            m_acc = 0;
            m_shots = 0;
            tick();  // EMIT cycle: no trigger can be accepted here
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; trig_in = 1'b0; din = '0;
        delay = '0; gate_len = '0; avg_log2 = '0; out_shift = '0;

        fork
            forever begin
                @(negedge clk);
                if (dout_valid) begin
                    if (sb_q.size() == 0) begin
                        check("spurious_valid", 1, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("dout", dout, mon_e.val);
                        check("valid_cycle", cyc, mon_e.at);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_dout", dout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_shot_cnt", shot_cnt, 0);
        check("rst_missed", missed_cnt, 0);
        reset = 1'b0;
        enable = 1'b1;
        tick(); tick();

        // constant 1000, delay 3, gate 4, single shot -> 4000
        do_shot(3, 4, 0, 0, 1, 1000, 0, 0);
        tick();
        check("shot_cnt_first", shot_cnt, 1);

        // four-shot average with shift 2 -> (100+200-300+400)/4 = 100
        do_shot(0, 1, 2, 2, 1, 100, 0, 0);
        do_shot(0, 1, 2, 2, 1, 200, 0, 0);
        do_shot(0, 1, 2, 2, 1, -300, 0, 0);
        do_shot(0, 1, 2, 2, 1, 400, 0, 0);

        // output saturation both ways, and shift 63 of a negative sum
        do_shot(0, 8, 0, 0, 1, 32767, 0, 0);
        do_shot(0, 8, 0, 0, 1, -32768, 0, 0);
        do_shot(0, 2, 0, 63, 1, -7, 0, 0);

        // second edge during a long gate is ignored
        do_shot(0, 20, 0, 0, 0, 0, 5, 0);
        tick();
        check("missed_after_retrig", missed_cnt, exp_missed);

        // enable drop after one shot discards it
        do_shot(1, 3, 1, 0, 0, 0, 0, 0);
        tick(); enable = 1'b0;
        tick(); enable = 1'b1;
        m_acc = 0; m_shots = 0;
        // enable drop mid-shot aborts it
        tick(); delay = 16'd2; gate_len = 16'd5; avg_log2 = 5'd1; trig_in = 1'b1; exp_shots++;
        tick(); trig_in = 1'b0;
        tick(); tick(); enable = 1'b0;
        tick(); enable = 1'b1;
        check("busy_after_abort", busy, 0);
        do_shot(2, 3, 1, 1, 0, 0, 0, 0);
        do_shot(2, 3, 1, 1, 0, 0, 0, 0);

        // gate 0 acts as 1; trigger held high counts once
        do_shot(0, 0, 0, 0, 1, 5, 0, 1);
        repeat (48) tick();
        trig_in = 1'b0;
        tick();
        check("shot_cnt_hold", shot_cnt, exp_shots);

        // randomized batches
        for (int b = 0; b < 20; b++) begin
            int n  = $urandom_range(0, 2);
            int sh = $urandom_range(0, 3);
            for (int s = 0; s < (1 << n); s++)
                do_shot($urandom_range(0, 4), $urandom_range(0, 6), n, sh, 0, 0, 0, 0);
        end
        repeat (4) tick();
        check("sb_drained", sb_q.size(), 0);
        check("shot_cnt_final", shot_cnt, exp_shots);
        check("missed_final", missed_cnt, exp_missed);

        // async reset in the middle of DELAY
        tick(); delay = 16'd10; gate_len = 16'd2; avg_log2 = 5'd0; trig_in = 1'b1;
        tick(); trig_in = 1'b0;
        tick(); tick();
        check("busy_in_delay", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_dout", dout, 0);
        check("arst_valid", dout_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_shot_cnt", shot_cnt, 0);
        check("arst_missed", missed_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
